// File: rtl/br_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between
// the ALU writeback path (A) and the load return path (B).
module br_write_arbiter #(
    parameter int AW           = 5,
    parameter int DWID         = 32,
    parameter int ZERO_PROTECT = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             a_valid,
    input  logic [AW-1:0]    a_addr,
    input  logic [DWID-1:0]  a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [AW-1:0]    b_addr,
    input  logic [DWID-1:0]  b_data,
    output logic             b_ready,
    output logic [AW-1:0]    WR,
    output logic [DWID-1:0]  DW,
    output logic             RegEn,
    output logic [CNT_W-1:0] wr_count,
    output logic             last_b
);

    logic            grant_a;
    logic            grant_b;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DWID-1:0] sel_data;
    logic            zero_hit;
    logic            commit;

    // On a tie the side that did not win last time is granted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && !stall) begin
            grant_a = a_valid && (!b_valid || last_b);
            grant_b = b_valid && (!a_valid || !last_b);
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign xfer    = grant_a || grant_b;

    always_comb begin
        sel_addr = a_addr;
        sel_data = a_data;
        if (grant_b) begin
            sel_addr = b_addr;
            sel_data = b_data;
        end
    end

    assign zero_hit = (ZERO_PROTECT != 0) && (sel_addr == '0);
    assign commit   = xfer && !zero_hit;

    // wr_count advances together with the RegEn it counts, so it already
    // includes the pulse currently on the bank port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WR       <= '0;
            DW       <= '0;
            RegEn    <= 1'b0;
            wr_count <= '0;
            last_b   <= 1'b1;
        end else begin
            RegEn <= commit;
            if (xfer) begin
                WR     <= sel_addr;
                DW     <= sel_data;
                last_b <= grant_b;
            end
            if (commit && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_br_write_arbiter.sv
// Directed bench for br_write_arbiter; a second instance with a tiny counter
// and zero-protection off covers saturation and unprotected address 0.
module tb_br_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;

    logic        a_ready, b_ready, RegEn, last_b;
    logic [4:0]  WR;
    logic [31:0] DW;
    logic [15:0] wr_count;

    logic        a_ready2, b_ready2, RegEn2, last_b2;
    logic [4:0]  WR2;
    logic [31:0] DW2;
    logic [1:0]  wr_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    br_write_arbiter #(.AW(5), .DWID(32), .ZERO_PROTECT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .WR(WR), .DW(DW), .RegEn(RegEn), .wr_count(wr_count), .last_b(last_b)
    );

    br_write_arbiter #(.AW(5), .DWID(32), .ZERO_PROTECT(0), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready2),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready2),
        .WR(WR2), .DW(DW2), .RegEn(RegEn2), .wr_count(wr_count2), .last_b(last_b2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
        step();
        step();
        check("rst_a_ready", a_ready, 0);
        check("rst_RegEn", RegEn, 0);
        check("rst_WR", WR, 0);
        check("rst_DW", DW, 0);
        check("rst_count", wr_count, 0);
        check("rst_last_b", last_b, 1);

        // Single A write
        rst_n = 1'b1; a_data = 32'hDEADBEEF;
        #1;
        check("t1_a_ready", a_ready, 1);
        check("t1_b_ready", b_ready, 0);
        step();
        a_valid = 1'b0;
        check("t1_WR", WR, 5);
        check("t1_DW", DW, 32'hDEADBEEF);
        check("t1_RegEn", RegEn, 1);
        check("t1_count", wr_count, 1);
        check("t1_last_b", last_b, 0);

        // B writes $zero: consumed but suppressed on the protected instance
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
        #1;
        check("z_b_ready", b_ready, 1);
        check("z_a_ready", a_ready, 0);
        step();
        b_valid = 1'b0;
        check("z_RegEn", RegEn, 0);
        check("z_count", wr_count, 1);
        check("z_last_b", last_b, 1);
        check("z_DW", DW, 32'h1234);
        check("z_RegEn_unprot", RegEn2, 1);

        // Both valid for 4 cycles: A,B,A,B
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
            step();
            check("rr_RegEn", RegEn, 1);
            check("rr_WR", WR, (i % 2 == 0) ? 1 : 2);
            check("rr_last_b", last_b, (i % 2 == 1) ? 1 : 0);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        check("idle_RegEn", RegEn, 0);
        check("idle_WR_hold", WR, 2);
        check("idle_count", wr_count, 5);

        // Stall for 3 cycles, then exactly one write
        stall = 1'b1; a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_a_ready", a_ready, 0);
            step();
            check("st_RegEn", RegEn, 0);
        end
        stall = 1'b0;
        #1;
        check("st_release_ready", a_ready, 1);
        step();
        a_valid = 1'b0; stall = 1'b1;
        #1;
        check("st_pulse_kept", RegEn, 1);
        check("st_WR", WR, 7);
        step();
        stall = 1'b0;
        check("st_after", RegEn, 0);
        check("st_count", wr_count, 6);
        check("st_last_b", last_b, 0);

        // Transfer, then reset on the next edge
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        step();
        rst_n = 1'b0;
        #1;
        check("mr_ready_in_rst", a_ready, 0);
        step();
        check("mr_RegEn", RegEn, 0);
        check("mr_WR", WR, 0);
        check("mr_DW", DW, 0);
        check("mr_count", wr_count, 0);
        check("mr_last_b", last_b, 1);
        check("mr_count_small", wr_count2, 0);
        rst_n = 1'b1;
        a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        #1;
        check("mr_first_a", a_ready, 1);
        check("mr_first_b", b_ready, 0);
        check("mr_no_write", RegEn, 0);
        step();
        check("mr_WR", WR, 3);
        check("mr_count1", wr_count, 1);
        check("sat_c1", wr_count2, 1);

        // Saturation on the 2-bit counter: 2,3,3,3
        for (int i = 0; i < 4; i++) begin
            step();
            check("sat_small", wr_count2, (i == 0) ? 2 : 3);
            check("sat_RegEn", RegEn2, 1);
        end
        check("sat_main", wr_count, 5);
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
